fetch_seq: RTL

//  Instruction-fetch sequencer: owns the 32-bit program counter and drives the imem request handshake.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_seq_if.sv | 23 ++
 rtl/fetch_next_pc.sv | 41 ++++
 rtl/fetch_seq.sv | 103 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    DRAIN,
    HOLD,
    HALT
  } fetch_state_e;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_seq_if.sv
// Instruction-memory request bus and decode hand-off bus of the fetch sequencer.
interface fetch_seq_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection: redirect (or trap) beats a completed fetch (+4), otherwise hold.
// Alignment trapping is enabled by defining PC_ALIGN_CHECK_EN.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [31:0] pc_q,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc_d,
  output logic        trap
);

`ifndef PC_ALIGN_CHECK_EN
  // Low target bits and the trap vector have no effect without alignment checking.
  logic unused_align;
  assign unused_align = ^{redirect_pc[1:0], TRAP_VECTOR};
`endif

  always_comb begin
    pc_d = pc_q;
    trap = 1'b0;
    if (redirect_valid) begin
`ifdef PC_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        pc_d = TRAP_VECTOR;
        trap = 1'b1;
      end else begin
        pc_d = redirect_pc;
      end
`else
      pc_d = {redirect_pc[31:2], 2'b00};
`endif
    end else if (advance) begin
      pc_d = pc_q + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, drives imem requests, buffers one word for decode.
// Optional misaligned-redirect trapping under PC_ALIGN_CHECK_EN.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_seq_if.master       bus,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic              halted,
  output logic              trap_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         trap_q, trap_d;
  logic         advance;

  assign advance = (state_q == REQ) && bus.imem_ack;

  fetch_next_pc #(.TRAP_VECTOR(TRAP_VECTOR)) u_next_pc (
    .pc_q           (pc_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .pc_d           (pc_d),
    .trap           (trap_d)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (redirect_valid) begin
          // Without an ack the request is still outstanding and must be drained.
          state_d = bus.imem_ack ? REQ : DRAIN;
        end else if (bus.imem_ack) begin
          instr_d       = bus.imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      DRAIN: if (bus.imem_ack) state_d = REQ;
      HOLD: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end else if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = halt ? HALT : REQ;
        end
      end
      HALT: if (redirect_valid) state_d = REQ;
      default: state_d = BOOT;
    endcase
    // Address only moves when a fresh request starts, so it is stable while outstanding.
    if (state_d == REQ) addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      addr_q        <= RESET_VECTOR;
      instr_q       <= INSTR_NOP;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      trap_q        <= trap_d;
    end
  end

  assign bus.imem_req    = (state_q == REQ) || (state_q == DRAIN);
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign halted          = (state_q == HALT);
  assign trap_valid      = trap_q;

endmodule
